counter_seq_ctrl: RTL and testbench
===================================

// Module: counter_seq_ctrl
// PURPOSE
//  Sequencer for the 4-bit synchronous up-counter datapath on the board clock.
//  Replaces the divided-clock scheme: every flop runs on clk, and the counter advances on a one-cycle
//  clock-enable pulse (cnt_en). Start/stop/clear buttons drive a RUN/PAUSE/DONE FSM.
//  Count terminates at a programmable target (one-shot) or wraps modulo target (continuous).
// PARAMETERS
//  CNT_W    4          counter width in bits
//  DIV_W    26         divider width in bits
//  DIV_MAX  26'h3FFFFFF  divider terminal value; tick period = DIV_MAX+1 clk cycles (use 3 in sim)
// PORTS
//  clk        in   1      board clock (100 MHz); the only clock
//  rst        in   1      synchronous, active-high reset
//  start      in   1      start/resume request, level; rising edge acts
//  stop       in   1      pause request, level; rising edge acts
//  clear      in   1      abort/clear request, level; rising edge acts
//  oneshot    in   1      1 = stop in DONE at target; 0 = continuous modulo-target
//  target     in   CNT_W  terminal count; 0 = full 2^CNT_W range
//  cnt_q      in   CNT_W  current counter value, fed back from datapath
//  cnt_en     out  1      one-cycle increment enable to counter
//  cnt_clr    out  1      one-cycle synchronous clear to counter
//  done       out  1      one-cycle pulse on reaching target
//  busy       out  1      high in RUN or PAUSE
//  state      out  2      FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3
// BEHAVIOUR
//  - start/stop/clear are already synchronous to clk. Rising edges are detected against a registered
//    copy of each input. A held button acts once. All outputs are registered.
//  - Reset: state=IDLE, divider=0, edge regs=0, cnt_en=0, done=0, busy=0, cnt_clr=1.
//    cnt_clr stays high while rst=1, so the reset-less counter flops are cleared.
//  - Divider: counts 0..DIV_MAX and advances only in RUN. tick=1 when div==DIV_MAX; it then wraps to 0.
//    The divider is cleared when IDLE->RUN or DONE->RUN, and held (not cleared) in PAUSE.
//  - Terminal (term): tick && (cnt_q+1 mod 2^CNT_W) == target. target=0 means term when cnt_q is all ones.
//  - Event priority in every state: clear > stop > start > term.
//  - IDLE:  clear -> cnt_clr pulse, stay IDLE.
//           start -> RUN; the first cnt_en occurs DIV_MAX+1 cycles later.
//           stop is ignored.
//  - RUN:   clear -> cnt_clr pulse, go to IDLE.
//           stop  -> PAUSE; no cnt_en in that cycle.
//           tick && !term -> cnt_en pulse.
//           tick && term && oneshot  -> cnt_en + done pulses, go to DONE.
//           tick && term && !oneshot -> cnt_clr + done pulses (cnt_en=0), stay RUN.
//           In both term cases target=0 -> cnt_en instead of cnt_clr (natural wrap).
//  - PAUSE: start -> RUN; divider resumes from its held value. clear -> cnt_clr pulse, go to IDLE.
//  - DONE:  cnt_q holds target (or 0 if target=0). start -> cnt_clr pulse, divider cleared, go to RUN.
//           clear -> cnt_clr pulse, go to IDLE.
//  - cnt_en and cnt_clr are never high in the same cycle. Response latency is one cycle:
//    the edge sampled at clk N is reflected on the outputs after clk N.
//  - A change of target mid-RUN takes effect at the next tick compare. No other side effects.
//  - Reset mid-RUN: all of the above reset values apply on the next edge. No pending done is emitted.
// STRUCTURE
//  - Shared include counter_defs.vh: state localparams (ST_IDLE..ST_DONE) and CNT_W default.
//  - Sub-module tick_gen (DIV_W, DIV_MAX): ports clk, rst, run, clr, tick. Implements the divider.
//  - Top level: edge detectors, FSM, and output registers. Counter datapath stays outside this block.
// TESTING (DIV_MAX=3, counter model attached, target=5 unless noted)
//  - Reset held for 3 cycles -> cnt_clr=1 throughout, state=0, cnt_en=0.
//    One cycle after release -> cnt_clr=0.
//  - Pulse start, oneshot=1 -> cnt_en every 4th cycle, cnt_q 1,2,3,4,5.
//    done pulses with the 5th cnt_en; state=3, cnt_q stays 5.
//  - oneshot=0 -> cnt_q 1..4 then 0; done pulses every 5 ticks; state stays 1.
//    With target=0: cnt_q 15 -> 0 via cnt_en.
//  - Start, then stop 2 cycles after a tick, wait 10 cycles, then start -> next cnt_en 2 cycles
//    after resume (divider held), no lost or extra count.
//  - stop and clear rise in the same cycle during RUN -> cnt_clr pulse, state=0, cnt_q=0.
//    start held high for 20 cycles from IDLE -> exactly one IDLE->RUN transition.
//  - From DONE, start -> one cnt_clr pulse, state=1, cnt_q 0 then 1 after 4 cycles.
//    Assertion throughout all tests: !(cnt_en && cnt_clr).

Source files
------------

// File: rtl/counter_seq_ctrl_pkg.sv
// rtl/counter_seq_ctrl_pkg.sv - shared state encoding and default widths for the counter sequencer
// Purpose: FSM state type (codes are visible on the state port) and default parameter values.
package counter_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned DIV_W_DEF = 26;

endpackage

// File: rtl/counter_seq_ctrl_tick_gen.sv
// rtl/counter_seq_ctrl_tick_gen.sv - free-running divider producing the count tick
// Purpose: counts 0..DIV_MAX while run is high and wraps; tick flags the terminal value.
// Ports:
//   clk   in  board clock
//   rst   in  synchronous active-high reset
//   run   in  advance the divider this cycle
//   clr   in  restart the divider from 0 (wins over run)
//   tick  out high while the divider holds DIV_MAX
module tick_gen #(
    parameter int unsigned       DIV_W   = 26,
    parameter logic [DIV_W-1:0]  DIV_MAX = {DIV_W{1'b1}}
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_MAX);

    // When run is low the value is held, so a paused sequence resumes mid-period.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div <= '0;
        end else if (run) begin
            div <= tick ? '0 : div + 1'b1;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - RUN/PAUSE/DONE sequencer driving the counter enable and clear
// Purpose: detects button edges, runs the FSM and registers the counter control outputs.
// Ports:
//   clk      in  board clock, the only clock
//   rst      in  synchronous active-high reset
//   start    in  start/resume level, rising edge acts
//   stop     in  pause level, rising edge acts
//   clear    in  abort/clear level, rising edge acts
//   oneshot  in  1 = stop in DONE at target, 0 = wrap modulo target
//   target   in  terminal count, 0 = full range
//   cnt_q    in  counter value fed back from the datapath
//   cnt_en   out one-cycle increment enable
//   cnt_clr  out one-cycle synchronous clear (held high during reset)
//   done     out one-cycle pulse on reaching target
//   busy     out high in RUN or PAUSE
//   state    out FSM state code
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int unsigned       CNT_W   = CNT_W_DEF,
    parameter int unsigned       DIV_W   = DIV_W_DEF,
    parameter logic [DIV_W-1:0]  DIV_MAX = {DIV_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    logic             start_q;
    logic             stop_q;
    logic             clear_q;
    logic             start_rise;
    logic             stop_rise;
    logic             clear_rise;
    state_t           cur_state;
    state_t           nxt_state;
    logic             en_n;
    logic             clr_n;
    logic             done_n;
    logic             div_run;
    logic             div_clr;
    logic             tick;
    logic             term;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            clear_q <= clear;
        end
    end

    assign start_rise = start & ~start_q;
    assign stop_rise  = stop & ~stop_q;
    assign clear_rise = clear & ~clear_q;

    tick_gen #(
        .DIV_W   (DIV_W),
        .DIV_MAX (DIV_MAX)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (div_run),
        .clr  (div_clr),
        .tick (tick)
    );

    // Wrapping increment makes target=0 terminate at all-ones without a special case.
    assign cnt_inc = cnt_q + 1'b1;
    assign term    = tick && (cnt_inc == target);

    always_comb begin
        nxt_state = cur_state;
        en_n      = 1'b0;
        clr_n     = 1'b0;
        done_n    = 1'b0;
        div_run   = 1'b0;
        div_clr   = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (clear_rise) begin
                    clr_n = 1'b1;
                end else if (start_rise) begin
                    nxt_state = ST_RUN;
                    div_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_rise) begin
                    clr_n     = 1'b1;
                    nxt_state = ST_IDLE;
                end else if (stop_rise) begin
                    // Divider is not advanced here, so a tick swallowed by the stop
                    // is delivered on the first cycle after resume.
                    nxt_state = ST_PAUSE;
                end else begin
                    div_run = 1'b1;
                    if (tick) begin
                        if (term) begin
                            done_n = 1'b1;
                            if (oneshot) begin
                                nxt_state = ST_DONE;
                            end
                            // Continuous mode restarts from 0 by clearing, except at the
                            // full range where the increment itself wraps to 0.
                            if (oneshot || target == '0) begin
                                en_n = 1'b1;
                            end else begin
                                clr_n = 1'b1;
                            end
                        end else begin
                            en_n = 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (clear_rise) begin
                    clr_n     = 1'b1;
                    nxt_state = ST_IDLE;
                end else if (start_rise) begin
                    nxt_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (clear_rise) begin
                    clr_n     = 1'b1;
                    nxt_state = ST_IDLE;
                end else if (start_rise) begin
                    clr_n     = 1'b1;
                    div_clr   = 1'b1;
                    nxt_state = ST_RUN;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // cnt_clr is forced high during reset so the reset-less counter flops get cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b1;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            cnt_en  <= en_n;
            cnt_clr <= clr_n;
            done    <= done_n;
            busy    <= (nxt_state == ST_RUN) || (nxt_state == ST_PAUSE);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - self-checking bench for counter_seq_ctrl with attached counter
module tb_counter_seq_ctrl;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       oneshot = 1'b1;
    logic [3:0] target = 4'd5;
    logic [3:0] cnt_q = 4'd0;
    logic       cnt_en;
    logic       cnt_clr;
    logic       done;
    logic       busy;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    counter_seq_ctrl #(
        .CNT_W   (4),
        .DIV_W   (26),
        .DIV_MAX (26'd3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .oneshot (oneshot),
        .target  (target),
        .cnt_q   (cnt_q),
        .cnt_en  (cnt_en),
        .cnt_clr (cnt_clr),
        .done    (done),
        .busy    (busy),
        .state   (state)
    );

    always #5 clk = ~clk;

    // Counter datapath attached to the sequencer outputs.
    always @(posedge clk) begin
        if (cnt_clr) cnt_q <= 4'd0;
        else if (cnt_en) cnt_q <= cnt_q + 4'd1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode codes, elapsed RUN cycles and an integer counter.
    int m_state = 0;
    int m_elapsed = 0;
    int m_cnt = 0;
    bit m_en = 0;
    bit m_clr = 1;
    bit m_done = 0;
    bit m_busy = 0;
    bit p_start = 0;
    bit p_stop = 0;
    bit p_clear = 0;

    always @(posedge clk) begin : ref_model
        bit rs, sp, cl, tk, tm, e, c, d;
        int nxt_cnt;
        nxt_cnt = m_clr ? 0 : (m_en ? (m_cnt + 1) % 16 : m_cnt);
        e = 0; c = 0; d = 0;
        if (rst) begin
            m_state = 0; m_elapsed = 0;
            p_start = 0; p_stop = 0; p_clear = 0;
            c = 1;
        end else begin
            rs = start && !p_start;
            sp = stop && !p_stop;
            cl = clear && !p_clear;
            p_start = start; p_stop = stop; p_clear = clear;
            tk = (m_state == 1) && (m_elapsed % P == P - 1);
            tm = tk && (((m_cnt + 1) % 16) == int'(target));
            if (cl) begin
                c = 1;
                m_state = 0;
            end else begin
                case (m_state)
                    0: if (rs) begin m_state = 1; m_elapsed = 0; end
                    1: begin
                        if (sp) m_state = 2;
                        else begin
                            m_elapsed++;
                            if (tm) begin
                                d = 1;
                                if (oneshot || target == 0) e = 1; else c = 1;
                                if (oneshot) m_state = 3;
                            end else if (tk) e = 1;
                        end
                    end
                    2: if (rs) m_state = 1;
                    default: if (rs) begin m_state = 1; m_elapsed = 0; c = 1; end
                endcase
            end
        end
        m_cnt = nxt_cnt;
        m_en = e; m_clr = c; m_done = d;
        m_busy = (m_state == 1) || (m_state == 2);
    end

    always @(negedge clk) begin
        check("state", state, m_state);
        check("cnt_en", cnt_en, m_en);
        check("cnt_clr", cnt_clr, m_clr);
        check("done", done, m_done);
        check("busy", busy, m_busy);
        check("cnt_q", cnt_q, m_cnt);
        check("en_clr_excl", cnt_en & cnt_clr, 0);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int limit);
        int n = 0;
        while (int'(state) != s && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", state, s);
    endtask

    task automatic wait_en(input int limit);
        int n = 0;
        while (!cnt_en && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_en", cnt_en, 1);
    endtask

    initial begin
        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_clr", cnt_clr, 1);
            check("rst_state", state, 0);
            check("rst_en", cnt_en, 0);
        end
        rst = 1'b0;
        cycles(1);
        check("post_rst_clr", cnt_clr, 0);

        // One-shot to target 5.
        start = 1'b1; cycles(1); start = 1'b0;
        wait_state(3, 80);
        cycles(6);
        check("oneshot_cnt", cnt_q, 5);
        check("oneshot_state", state, 3);

        // Continuous, then full-range wrap.
        clear = 1'b1; cycles(1); clear = 1'b0;
        cycles(2);
        check("clear_cnt", cnt_q, 0);
        oneshot = 1'b0;
        start = 1'b1; cycles(1); start = 1'b0;
        cycles(60);
        check("cont_state", state, 1);
        target = 4'd0;
        cycles(80);
        clear = 1'b1; cycles(1); clear = 1'b0;
        cycles(2);
        check("cont_clear_state", state, 0);

        // Pause two cycles after a tick, resume later.
        target = 4'd5;
        start = 1'b1; cycles(1); start = 1'b0;
        wait_en(20);
        cycles(1);
        stop = 1'b1; cycles(1); stop = 1'b0;
        cycles(10);
        check("pause_state", state, 2);
        start = 1'b1; cycles(1); start = 1'b0;
        cycles(12);

        // stop and clear rising together.
        stop = 1'b1; clear = 1'b1; cycles(1); stop = 1'b0; clear = 1'b0;
        cycles(2);
        check("stopclr_state", state, 0);
        check("stopclr_cnt", cnt_q, 0);

        // Held start acts once.
        start = 1'b1; cycles(20); start = 1'b0;
        check("held_start_state", state, 1);

        // Restart from DONE.
        clear = 1'b1; cycles(1); clear = 1'b0;
        oneshot = 1'b1;
        cycles(1);
        start = 1'b1; cycles(1); start = 1'b0;
        wait_state(3, 100);
        cycles(2);
        start = 1'b1; cycles(1); start = 1'b0;
        cycles(1);
        check("restart_state", state, 1);
        check("restart_cnt", cnt_q, 0);
        cycles(8);

        // Randomized buttons, modes, targets and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 99) < 8);
            stop  = ($urandom_range(0, 99) < 4);
            clear = ($urandom_range(0, 99) < 2);
            rst   = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 99) == 0) oneshot = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) target = 4'($urandom_range(0, 15));
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
